// File: rtl/pipe_adder.sv
// Segmented pipelined adder: N = WIDTH/SEG stages, SEG bits per stage.
// Optional ovf output when PIPE_ADDER_OVF_EN is defined.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   a, b, ci   operands and carry-in, taken on in_valid & in_ready
//   in_valid   operand set present
//   in_ready   block accepts an operand set (equals global advance)
//   sum, co    a+b+ci modulo 2^WIDTH and carry out of the MSB
//   out_valid  sum/co (and ovf) hold a valid result
//   out_ready  consumer accepts the result this cycle
//   ovf        signed overflow, only with PIPE_ADDER_OVF_EN
module pipe_adder #(
   parameter int WIDTH = 8,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
   output logic             out_valid,
   input  logic             out_ready
`ifdef PIPE_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int N = WIDTH / SEG;

   // Per-stage state: operands travel with the transaction, the sum
   // accumulates completed segments, carry feeds the next segment.
   logic [WIDTH-1:0] a_q [N];
   logic [WIDTH-1:0] a_d [N];
   logic [WIDTH-1:0] b_q [N];
   logic [WIDTH-1:0] b_d [N];
   logic [WIDTH-1:0] s_q [N];
   logic [WIDTH-1:0] s_d [N];
   logic [N-1:0]     c_q;
   logic [N-1:0]     c_d;
   logic [N-1:0]     v_q;
   logic [N-1:0]     v_d;

   logic en;

   // One global stall: the whole pipe moves only if the last slot
   // is empty or being drained.
   assign en        = out_ready | ~v_q[N-1];
   assign in_ready  = en;
   assign out_valid = v_q[N-1];
   assign sum       = s_q[N-1];
   assign co        = c_q[N-1];

   always_comb begin
      logic [WIDTH-1:0] ap;
      logic [WIDTH-1:0] bp;
      logic [WIDTH-1:0] sp;
      logic             cin;
      logic             vin;
      logic [SEG:0]     seg;
      ap  = '0;
      bp  = '0;
      sp  = '0;
      cin = 1'b0;
      vin = 1'b0;
      seg = '0;
      for (int k = 0; k < N; k++) begin
         a_d[k] = '0;
         b_d[k] = '0;
         s_d[k] = '0;
      end
      c_d = '0;
      v_d = '0;
      for (int k = 0; k < N; k++) begin
         if (k == 0) begin
            ap  = a;
            bp  = b;
            sp  = '0;
            cin = ci;
            vin = in_valid;
         end else begin
            ap  = a_q[k-1];
            bp  = b_q[k-1];
            sp  = s_q[k-1];
            cin = c_q[k-1];
            vin = v_q[k-1];
         end
         seg = {1'b0, ap[k*SEG +: SEG]}
             + {1'b0, bp[k*SEG +: SEG]}
             + {{SEG{1'b0}}, cin};
         sp[k*SEG +: SEG] = seg[SEG-1:0];
         a_d[k] = ap;
         b_d[k] = bp;
         s_d[k] = sp;
         c_d[k] = seg[SEG];
         v_d[k] = vin;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
         c_q <= '0;
         v_q <= '0;
      end else if (en) begin
         for (int k = 0; k < N; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
         end
         c_q <= c_d;
         v_q <= v_d;
      end
   end

`ifdef PIPE_ADDER_OVF_EN
   logic ovf_q;
   logic ovf_d;
   logic cmsb;

   // Carry into the MSB recovered from the MSB sum bit and operands.
   assign cmsb  = a_d[N-1][WIDTH-1]
                ^ b_d[N-1][WIDTH-1]
                ^ s_d[N-1][WIDTH-1];
   assign ovf_d = cmsb ^ c_d[N-1];
   assign ovf   = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (en) begin
         ovf_q <= ovf_d;
      end
   end
`endif

endmodule
